// File: rtl/dump_seq.sv
// Channel dump sequencer: streams the circular capture RAM oldest-sample-first to the UART.
// Define DUMP_HDR_EN to prefix each dump with a channel header byte (8'hA0 | ch).
module dump_seq #(
    parameter int unsigned ADDR_W = 9
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              dump_i,
    input  logic [1:0]        dump_ch_i,
    input  logic              capture_done_i,
    input  logic [ADDR_W-1:0] trace_end_i,
    input  logic [7:0]        ch1_rdata_i,
    input  logic [7:0]        ch2_rdata_i,
    input  logic [7:0]        ch3_rdata_i,
    output logic              en_o,
    output logic [ADDR_W-1:0] addr_o,
    output logic [7:0]        resp_data_o,
    output logic              send_resp_o,
    input  logic              resp_sent_i,
    output logic              dump_busy_o,
    output logic              dump_done_o,
    output logic              clr_cap_done_o
);

    localparam logic [9:0] LastCount = 10'((1 << ADDR_W) - 1);

    typedef enum logic [2:0] {
        StIdle = 3'd0,
        StHdr  = 3'd1,
        StRd   = 3'd2,
        StSend = 3'd3,
        StWait = 3'd4,
        StDone = 3'd5
    } state_e;

    state_e            state_q;
    logic              en_q, send_resp_q, dump_busy_q, dump_done_q, clr_cap_done_q;
    logic [ADDR_W-1:0] addr_q;
    logic [7:0]        resp_data_q;
    logic [9:0]        count_q;
    logic [1:0]        ch_q;
    logic              err_q, hdr_q, rd_second_q;
    logic [7:0]        rdata;

    always_comb begin
        rdata = ch1_rdata_i;
        case (ch_q)
            2'b01:   rdata = ch2_rdata_i;
            2'b10:   rdata = ch3_rdata_i;
            default: rdata = ch1_rdata_i;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q        <= StIdle;
            en_q           <= 1'b0;
            addr_q         <= '0;
            resp_data_q    <= 8'h00;
            send_resp_q    <= 1'b0;
            dump_busy_q    <= 1'b0;
            dump_done_q    <= 1'b0;
            clr_cap_done_q <= 1'b0;
            count_q        <= 10'd0;
            ch_q           <= 2'b00;
            err_q          <= 1'b0;
            hdr_q          <= 1'b0;
            rd_second_q    <= 1'b0;
        end else begin
            send_resp_q    <= 1'b0;
            dump_done_q    <= 1'b0;
            clr_cap_done_q <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    if (dump_i) begin
                        dump_busy_q <= 1'b1;
                        if (dump_ch_i == 2'b11 || !capture_done_i) begin
                            resp_data_q <= 8'hEE;
                            err_q       <= 1'b1;
                            send_resp_q <= 1'b1;
                            state_q     <= StSend;
                        end else begin
                            ch_q    <= dump_ch_i;
                            addr_q  <= trace_end_i + ADDR_W'(1);
                            count_q <= 10'd0;
                            err_q   <= 1'b0;
`ifdef DUMP_HDR_EN
                            hdr_q   <= 1'b1;
                            state_q <= StHdr;
`else
                            en_q        <= 1'b1;
                            rd_second_q <= 1'b0;
                            state_q     <= StRd;
`endif
                        end
                    end
                end
`ifdef DUMP_HDR_EN
                StHdr: begin
                    resp_data_q <= {6'b101000, ch_q};
                    send_resp_q <= 1'b1;
                    state_q     <= StSend;
                end
`endif
                // Synchronous RAM: data is valid in the second enable cycle.
                StRd: begin
                    if (!rd_second_q) begin
                        rd_second_q <= 1'b1;
                    end else begin
                        rd_second_q <= 1'b0;
                        en_q        <= 1'b0;
                        resp_data_q <= rdata;
                        send_resp_q <= 1'b1;
                        state_q     <= StSend;
                    end
                end
                StSend: state_q <= StWait;
                StWait: begin
                    if (resp_sent_i) begin
                        if (err_q) begin
                            err_q       <= 1'b0;
                            dump_busy_q <= 1'b0;
                            state_q     <= StIdle;
                        end else if (hdr_q) begin
                            hdr_q       <= 1'b0;
                            en_q        <= 1'b1;
                            rd_second_q <= 1'b0;
                            state_q     <= StRd;
                        end else if (count_q == LastCount) begin
                            dump_done_q    <= 1'b1;
                            clr_cap_done_q <= 1'b1;
                            state_q        <= StDone;
                        end else begin
                            count_q     <= count_q + 10'd1;
                            addr_q      <= addr_q + ADDR_W'(1);
                            en_q        <= 1'b1;
                            rd_second_q <= 1'b0;
                            state_q     <= StRd;
                        end
                    end
                end
                StDone: begin
                    dump_busy_q <= 1'b0;
                    state_q     <= StIdle;
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign en_o           = en_q;
    assign addr_o         = addr_q;
    assign resp_data_o    = resp_data_q;
    assign send_resp_o    = send_resp_q;
    assign dump_busy_o    = dump_busy_q;
    assign dump_done_o    = dump_done_q;
    assign clr_cap_done_o = clr_cap_done_q;

endmodule
